// File: rtl/clock_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clock_set_ctrl : RUN/SET sequencer for the Numitron clock counters    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module clock_set_ctrl #(
  parameter int REPEAT_DELAY = 4,
  parameter int REPEAT_RATE  = 1,
  parameter int TIMEOUT_S    = 30,
  parameter int FLASH_HALF   = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick_1hz,
  input  logic       tick_fast,
  input  logic       btn_mode,
  input  logic       btn_adv,
  input  logic       sec_ovfl,
  input  logic       min_ovfl,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hr,
  output logic       clr_sec,
  output logic       blank_hr,
  output logic       blank_min,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10
  } state_t;

  localparam int c_dly_w   = $clog2(REPEAT_DELAY + 1);
  localparam int c_rate_w  = $clog2(REPEAT_RATE + 1);
  localparam int c_to_w    = $clog2(TIMEOUT_S + 1);
  localparam int c_flash_w = $clog2(FLASH_HALF + 1);

  localparam logic [c_dly_w-1:0]   c_dly_end    = c_dly_w'(REPEAT_DELAY);
  localparam logic [c_rate_w-1:0]  c_rate_last  = c_rate_w'(REPEAT_RATE - 1);
  localparam logic [c_to_w-1:0]    c_to_last    = c_to_w'(TIMEOUT_S - 1);
  localparam logic [c_flash_w-1:0] c_flash_last = c_flash_w'(FLASH_HALF - 1);

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_mode_prev;
  logic                 r_adv_prev;
  logic                 r_mode_press;
  logic                 r_adv_press;
  logic                 r_armed;
  logic                 r_phase;
  logic [c_dly_w-1:0]   r_dly_cnt;
  logic [c_rate_w-1:0]  r_rate_cnt;
  logic [c_to_w-1:0]    r_to_cnt;
  logic [c_flash_w-1:0] r_flash_cnt;

  logic                 w_in_set;
  logic                 w_nxt_set;
  logic                 w_state_chg;
  logic                 w_timeout;
  logic                 w_adv_act;
  logic                 w_dly_done;
  logic                 w_rpt_fire;
  logic                 w_adv_inc;
  logic                 w_armed_nxt;
  logic                 w_phase_nxt;
  logic [c_dly_w-1:0]   w_dly_nxt;
  logic [c_rate_w-1:0]  w_rate_nxt;
  logic [c_to_w-1:0]    w_to_nxt;
  logic [c_flash_w-1:0] w_flash_nxt;

  assign w_in_set    = (r_state == ST_SET_HR) || (r_state == ST_SET_MIN);
  assign w_nxt_set   = (w_state_nxt != ST_RUN);
  assign w_state_chg = (w_state_nxt != r_state);
  assign w_timeout   = w_in_set && tick_1hz && (r_to_cnt == c_to_last);
  // MODE wins over a coincident ADV press; the ADV press is simply dropped.
  assign w_adv_act   = w_in_set && r_adv_press && !r_mode_press;
  assign w_dly_done  = (r_dly_cnt == c_dly_end);
  assign w_adv_inc   = w_adv_act || w_rpt_fire;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = ST_RUN;
    case (r_state)
      ST_RUN: begin
        w_state_nxt = r_mode_press ? ST_SET_HR : ST_RUN;
      end
      ST_SET_HR: begin
        if (w_timeout) begin
          w_state_nxt = ST_RUN;
        end else if (r_mode_press) begin
          w_state_nxt = ST_SET_MIN;
        end else begin
          w_state_nxt = ST_SET_HR;
        end
      end
      ST_SET_MIN: begin
        w_state_nxt = (w_timeout || r_mode_press) ? ST_RUN : ST_SET_MIN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // ------------------------------------------------ repeat/timeout/blink
  always_comb begin
    w_armed_nxt = r_armed;
    w_dly_nxt   = r_dly_cnt;
    w_rate_nxt  = r_rate_cnt;
    w_rpt_fire  = 1'b0;
    w_to_nxt    = r_to_cnt;
    w_flash_nxt = r_flash_cnt;
    w_phase_nxt = r_phase;

    // Repeat only runs for an ADV hold that began with an accepted press.
    if (w_state_chg || !btn_adv) begin
      w_armed_nxt = 1'b0;
      w_dly_nxt   = '0;
      w_rate_nxt  = '0;
    end else begin
      if (w_adv_act) begin
        w_armed_nxt = 1'b1;
      end
      if (r_armed && tick_fast) begin
        if (!w_dly_done) begin
          w_dly_nxt = r_dly_cnt + c_dly_w'(1);
        end else if (r_rate_cnt == c_rate_last) begin
          w_rate_nxt = '0;
          w_rpt_fire = 1'b1;
        end else begin
          w_rate_nxt = r_rate_cnt + c_rate_w'(1);
        end
      end
    end

    if (w_state_chg || !w_nxt_set || r_mode_press || r_adv_press) begin
      w_to_nxt = '0;
    end else if (tick_1hz) begin
      w_to_nxt = r_to_cnt + c_to_w'(1);
    end

    if (w_state_chg || !w_nxt_set) begin
      w_flash_nxt = '0;
      w_phase_nxt = 1'b0;
    end else if (tick_fast) begin
      if (r_flash_cnt == c_flash_last) begin
        w_flash_nxt = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_flash_nxt = r_flash_cnt + c_flash_w'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mode_prev  <= 1'b0;
      r_adv_prev   <= 1'b0;
      r_mode_press <= 1'b0;
      r_adv_press  <= 1'b0;
      r_armed      <= 1'b0;
      r_phase      <= 1'b0;
      r_dly_cnt    <= '0;
      r_rate_cnt   <= '0;
      r_to_cnt     <= '0;
      r_flash_cnt  <= '0;
    end else begin
      r_mode_prev  <= btn_mode;
      r_adv_prev   <= btn_adv;
      r_mode_press <= btn_mode && !r_mode_prev;
      r_adv_press  <= btn_adv && !r_adv_prev;
      r_armed      <= w_armed_nxt;
      r_phase      <= w_phase_nxt;
      r_dly_cnt    <= w_dly_nxt;
      r_rate_cnt   <= w_rate_nxt;
      r_to_cnt     <= w_to_nxt;
      r_flash_cnt  <= w_flash_nxt;
    end
  end

  // ------------------------------------------------------------ outputs
  // Level outputs follow the next state so they move together with mode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inc_sec   <= 1'b0;
      inc_min   <= 1'b0;
      inc_hr    <= 1'b0;
      clr_sec   <= 1'b0;
      blank_hr  <= 1'b0;
      blank_min <= 1'b0;
      mode      <= 2'b00;
    end else begin
      inc_sec   <= (r_state == ST_RUN) && tick_1hz;
      inc_min   <= ((r_state == ST_RUN) && sec_ovfl) ||
                   ((r_state == ST_SET_MIN) && w_adv_inc);
      inc_hr    <= ((r_state == ST_RUN) && min_ovfl) ||
                   ((r_state == ST_SET_HR) && w_adv_inc);
      clr_sec   <= w_nxt_set;
      blank_hr  <= (w_state_nxt == ST_SET_HR) && w_phase_nxt && !btn_adv;
      blank_min <= (w_state_nxt == ST_SET_MIN) && w_phase_nxt && !btn_adv;
      mode      <= w_state_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_clock_set_ctrl : directed + random bench with behavioural model    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_clock_set_ctrl;

  localparam int RD = 4;
  localparam int RR = 1;
  localparam int TO = 30;
  localparam int FH = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       tick_fast = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_adv = 1'b0;
  logic       sec_ovfl = 1'b0;
  logic       min_ovfl = 1'b0;
  logic       inc_sec;
  logic       inc_min;
  logic       inc_hr;
  logic       clr_sec;
  logic       blank_hr;
  logic       blank_min;
  logic [1:0] mode;
  logic [7:0] obs_vec;

  clock_set_ctrl #(
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .TIMEOUT_S   (TO),
    .FLASH_HALF  (FH)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .tick_1hz (tick_1hz),
    .tick_fast(tick_fast),
    .btn_mode (btn_mode),
    .btn_adv  (btn_adv),
    .sec_ovfl (sec_ovfl),
    .min_ovfl (min_ovfl),
    .inc_sec  (inc_sec),
    .inc_min  (inc_min),
    .inc_hr   (inc_hr),
    .clr_sec  (clr_sec),
    .blank_hr (blank_hr),
    .blank_min(blank_min),
    .mode     (mode)
  );

  assign obs_vec = {inc_sec, inc_min, inc_hr, clr_sec, blank_hr, blank_min, mode};

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt_sec, cnt_min, cnt_hr, cnt_blank_held;

  // Reference model: mode 0=RUN 1=SET_HR 2=SET_MIN, expressed as event counts.
  int         m_mode;
  bit         m_last_mode, m_last_adv, m_pend_mode, m_pend_adv, m_held_ok;
  int         m_held_ticks, m_idle, m_fast_since_entry;
  logic [7:0] m_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_last_mode = 0; m_last_adv = 0; m_pend_mode = 0; m_pend_adv = 0;
    m_held_ok = 0; m_held_ticks = 0; m_idle = 0; m_fast_since_entry = 0;
    m_exp = 8'h00;
  endtask

  task automatic model_step();
    bit mp, ap, in_set, timeout, changed, adv_ok, fire, phase;
    bit e_sec, e_min, e_hr;
    int nm;
    mp = m_pend_mode;
    ap = m_pend_adv;
    m_pend_mode = btn_mode && !m_last_mode;
    m_pend_adv  = btn_adv && !m_last_adv;
    m_last_mode = btn_mode;
    m_last_adv  = btn_adv;
    in_set  = (m_mode != 0);
    timeout = in_set && tick_1hz && (m_idle + 1 >= TO);
    nm = m_mode;
    if (timeout) nm = 0;
    else if (mp) nm = (m_mode + 1) % 3;
    changed = (nm != m_mode);
    adv_ok  = in_set && ap && !mp;
    fire = 0;
    if (changed || !btn_adv) begin
      m_held_ok = 0;
      m_held_ticks = 0;
    end else begin
      if (m_held_ok && tick_fast) begin
        m_held_ticks++;
        fire = (m_held_ticks > RD) && (((m_held_ticks - RD) % RR) == 0);
      end
      if (adv_ok) m_held_ok = 1;
    end
    e_sec = (m_mode == 0) && tick_1hz;
    e_min = ((m_mode == 0) && sec_ovfl) || ((m_mode == 2) && (adv_ok || fire));
    e_hr  = ((m_mode == 0) && min_ovfl) || ((m_mode == 1) && (adv_ok || fire));
    if (changed || nm == 0 || mp || ap) m_idle = 0;
    else if (tick_1hz) m_idle++;
    if (changed || nm == 0) m_fast_since_entry = 0;
    else if (tick_fast) m_fast_since_entry++;
    phase = ((m_fast_since_entry / FH) % 2) == 1;
    m_exp = {e_sec, e_min, e_hr, (nm != 0), (nm == 1) && phase && !btn_adv,
             (nm == 2) && phase && !btn_adv, 2'(nm)};
    m_mode = nm;
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (!rstn) model_reset();
      else model_step();
      #1;
      check("cycle", 32'(obs_vec), 32'(m_exp));
      cnt_sec += int'(inc_sec);
      cnt_min += int'(inc_min);
      cnt_hr  += int'(inc_hr);
      if (btn_adv && blank_hr) cnt_blank_held++;
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; step(2);
    btn_mode = 1'b0; step(2);
  endtask

  initial begin
    cnt_sec = 0; cnt_min = 0; cnt_hr = 0; cnt_blank_held = 0;
    model_reset();
    step(3);
    check("reset_outputs", 32'(obs_vec), 32'h0);
    rstn = 1'b1;
    step(2);

    // RUN: delayed strobes, coincident overflows
    step(5);
    tick_1hz = 1'b1; step(1); tick_1hz = 1'b0;
    check("run_inc_sec_hi", 32'(inc_sec), 32'd1);
    step(1);
    check("run_inc_sec_lo", 32'(inc_sec), 32'd0);
    step(5);
    sec_ovfl = 1'b1; min_ovfl = 1'b1; step(1); sec_ovfl = 1'b0; min_ovfl = 1'b0;
    check("run_min_hr_pair", 32'({inc_min, inc_hr}), 32'd3);

    // MODE press -> SET_HR two cycles later
    btn_mode = 1'b1; step(1);
    check("mode_lat1", 32'(mode), 32'd0);
    step(1);
    check("mode_set_hr", 32'(mode), 32'd1);
    btn_mode = 1'b0; step(2);
    check("set_clr_sec", 32'(clr_sec), 32'd1);
    cnt_sec = 0;
    repeat (3) begin tick_1hz = 1'b1; step(1); tick_1hz = 1'b0; step(4); end
    check("set_no_inc_sec", 32'(cnt_sec), 32'd0);
    cnt_min = 0;
    sec_ovfl = 1'b1; step(1); sec_ovfl = 1'b0; step(3);
    check("set_no_cascade_min", 32'(cnt_min), 32'd0);

    // ADV held for 10 tick_fast -> 1 + 6 increments, no blanking while held
    cnt_hr = 0; cnt_blank_held = 0;
    btn_adv = 1'b1; step(3);
    repeat (10) begin tick_fast = 1'b1; step(1); tick_fast = 1'b0; step(3); end
    btn_adv = 1'b0; step(3);
    check("adv_hold_count", 32'(cnt_hr), 32'd7);
    check("adv_hold_blank", 32'(cnt_blank_held), 32'd0);

    // SET_MIN: no hour cascade, ADV drives minutes, MODE back to RUN
    press_mode();
    check("mode_set_min", 32'(mode), 32'd2);
    cnt_hr = 0;
    min_ovfl = 1'b1; step(1); min_ovfl = 1'b0; step(3);
    check("set_min_no_hr", 32'(cnt_hr), 32'd0);
    cnt_min = 0;
    btn_adv = 1'b1; step(3); btn_adv = 1'b0; step(2);
    check("set_min_adv", 32'(cnt_min), 32'd1);
    btn_mode = 1'b1; step(2);
    check("exit_mode_run", 32'(mode), 32'd0);
    check("exit_clr_sec", 32'(clr_sec), 32'd0);
    btn_mode = 1'b0; step(2);
    tick_1hz = 1'b1; step(1); tick_1hz = 1'b0;
    check("exit_first_inc_sec", 32'(inc_sec), 32'd1);
    step(2);

    // Blink and timeout in SET_HR
    press_mode();
    repeat (2) begin tick_fast = 1'b1; step(1); tick_fast = 1'b0; step(2); end
    check("blink_on", 32'(blank_hr), 32'd1);
    repeat (2) begin tick_fast = 1'b1; step(1); tick_fast = 1'b0; step(2); end
    check("blink_off", 32'(blank_hr), 32'd0);
    repeat (29) begin tick_1hz = 1'b1; step(1); tick_1hz = 1'b0; step(2); end
    check("timeout_29", 32'(mode), 32'd1);
    btn_adv = 1'b1; step(3); btn_adv = 1'b0; step(2);
    repeat (29) begin tick_1hz = 1'b1; step(1); tick_1hz = 1'b0; step(2); end
    check("timeout_restart", 32'(mode), 32'd1);
    tick_1hz = 1'b1; step(1); tick_1hz = 1'b0;
    check("timeout_exit", 32'(mode), 32'd0);
    check("timeout_clr_sec", 32'(clr_sec), 32'd0);
    step(3);

    // Async reset mid-repeat in SET_MIN, then MODE+ADV together
    press_mode();
    press_mode();
    cnt_min = 0;
    btn_adv = 1'b1; step(3);
    repeat (6) begin tick_fast = 1'b1; step(1); tick_fast = 1'b0; step(2); end
    check("repeat_before_rst", 32'(cnt_min), 32'd3);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check("async_rst_outputs", 32'(obs_vec), 32'h0);
    btn_adv = 1'b0;
    step(3);
    rstn = 1'b1;
    step(2);
    cnt_hr = 0;
    btn_mode = 1'b1; btn_adv = 1'b1; step(3);
    check("both_press_mode", 32'(mode), 32'd1);
    repeat (6) begin tick_fast = 1'b1; step(1); tick_fast = 1'b0; step(2); end
    check("both_press_no_hr", 32'(cnt_hr), 32'd0);
    btn_mode = 1'b0; btn_adv = 1'b0; step(3);
    btn_adv = 1'b1; step(3); btn_adv = 1'b0; step(2);
    check("repress_adv_hr", 32'(cnt_hr), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if (i < 2000) begin
        tick_1hz = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 30) == 0) btn_mode = ~btn_mode;
        if ($urandom_range(0, 12) == 0) btn_adv = ~btn_adv;
      end else begin
        tick_1hz = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 300) == 0) btn_mode = ~btn_mode;
        if ($urandom_range(0, 200) == 0) btn_adv = ~btn_adv;
      end
      tick_fast = ($urandom_range(0, 3) == 0);
      sec_ovfl  = ($urandom_range(0, 20) == 0);
      min_ovfl  = ($urandom_range(0, 25) == 0);
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
